// File: rtl/pipe_pkg.sv
// Shared encodings and payload packing widths for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int XLEN    = 32;
    localparam int REG_A_W = 5;

    // Caller-side packing widths; each stage packs its fields MSB-first into one vector.
    localparam int IFID_W  = 2 * XLEN;
    localparam int IDEX_W  = 3 * XLEN + 3 * REG_A_W + 16;
    localparam int EXMEM_W = 2 * XLEN + REG_A_W + 8;
    localparam int MEMWB_W = XLEN + REG_A_W + 4;

endpackage

// File: rtl/stage_slot.sv
// One entry of a stage register: a valid bit plus a payload, with load and clear.
module stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int CLR_PAYLOAD = 1
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    // NOTE: the payload is reset too, so out_data reads zero rather than X after reset.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            if (CLR_PAYLOAD != 0) begin
                q <= '0;
            end
        end else if (load) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional two-entry skid buffer and flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int SKID        = 1,
    parameter int CLR_PAYLOAD = 1
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              push;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    stage_slot #(
        .DATA_W      (DATA_W),
        .CLR_PAYLOAD (CLR_PAYLOAD)
    ) u_main (
        .stg_clk (stg_clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .d       (main_d),
        .valid   (out_valid),
        .q       (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            occ_e              state_q;
            occ_e              state_d;
            logic              in_ready_q;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_q;

            stage_slot #(
                .DATA_W      (DATA_W),
                .CLR_PAYLOAD (CLR_PAYLOAD)
            ) u_skid (
                .stg_clk (stg_clk),
                .reset   (reset),
                .load    (skid_load),
                .clear   (skid_clear),
                .d       (in_data),
                .valid   (skid_valid),
                .q       (skid_q)
            );

            always_ff @(posedge stg_clk or negedge reset) begin
                if (!reset) begin
                    state_q    <= OCC_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != OCC_FULL);
                end
            end

            // NOTE: every output of this block gets a default first, so no latch is inferred.
            always_comb begin
                state_d    = state_q;
                main_load  = 1'b0;
                main_clear = 1'b0;
                main_d     = in_data;
                skid_load  = 1'b0;
                skid_clear = 1'b0;

                if (flush) begin
                    state_d    = OCC_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state_q)
                        OCC_EMPTY: begin
                            if (push) begin
                                main_load = 1'b1;
                                state_d   = OCC_ONE;
                            end
                        end
                        OCC_ONE: begin
                            if (push && pop) begin
                                main_load = 1'b1;
                            end else if (push) begin
                                skid_load = 1'b1;
                                state_d   = OCC_FULL;
                            end else if (pop) begin
                                main_clear = 1'b1;
                                state_d    = OCC_EMPTY;
                            end
                        end
                        OCC_FULL: begin
                            // Promote the skid entry; an empty skid here can only mean corrupted state.
                            if (pop) begin
                                main_d     = skid_q;
                                main_load  = skid_valid;
                                main_clear = ~skid_valid;
                                skid_clear = 1'b1;
                                state_d    = skid_valid ? OCC_ONE : OCC_EMPTY;
                            end
                        end
                        default: begin
                            state_d    = OCC_EMPTY;
                            main_clear = 1'b1;
                            skid_clear = 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = in_ready_q;
            assign occupancy = state_q;
        end else begin : g_single
            assign in_ready  = ~out_valid | out_ready;
            assign occupancy = {1'b0, out_valid};

            always_comb begin
                main_d     = in_data;
                main_load  = 1'b0;
                main_clear = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                end else if (push) begin
                    main_load = 1'b1;
                end else if (pop) begin
                    main_clear = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one skid-buffered instance and one single-register instance of pipe_stage_reg.
module tb_pipe_stage_reg;

    localparam int W = 8;

    logic         stg_clk;
    logic         reset;
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;

    int n_cmp;
    int n_err;

    pipe_stage_reg #(.DATA_W(W), .SKID(1), .CLR_PAYLOAD(1)) u_skid (
        .stg_clk   (stg_clk),
        .reset     (reset),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(0), .CLR_PAYLOAD(1)) u_single (
        .stg_clk   (stg_clk),
        .reset     (reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    initial begin
        stg_clk = 1'b0;
        forever #5 stg_clk = ~stg_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic [1:0] occ,
                           input logic rdy, input logic [W-1:0] data);
        check({tag, ".out_valid"}, 32'(a_out_valid), 32'(v));
        check({tag, ".occupancy"}, 32'(a_occ), 32'(occ));
        check({tag, ".in_ready"}, 32'(a_in_ready), 32'(rdy));
        check({tag, ".out_data"}, 32'(a_out_data), 32'(data));
    endtask

    initial begin
        logic [W-1:0] stream [3];
        n_cmp = 0;
        n_err = 0;
        stream[0] = 8'h01;
        stream[1] = 8'h02;
        stream[2] = 8'h03;
        reset = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

        // Reset release
        step();
        step();
        @(negedge stg_clk);
        reset = 1'b1;
        #1;
        check_a("reset", 1'b0, 2'd0, 1'b1, 8'h00);
        check("reset.b_out_valid", 32'(b_out_valid), 32'd0);
        check("reset.b_in_ready", 32'(b_in_ready), 32'd1);

        // Streaming with downstream always ready
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = stream[i];
            step();
            check_a($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1, stream[i]);
        end
        a_in_valid = 1'b0;
        step();
        check_a("stream_drain", 1'b0, 2'd0, 1'b1, 8'h00);

        // Stall into the skid entry
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h0A;
        step();
        check_a("stall_a", 1'b1, 2'd1, 1'b1, 8'h0A);
        a_in_data = 8'h0B;
        step();
        check_a("stall_full", 1'b1, 2'd2, 1'b0, 8'h0A);
        a_in_data   = 8'h0C;
        a_out_ready = 1'b1;
        step();
        check_a("drain_b", 1'b1, 2'd1, 1'b1, 8'h0B);
        step();
        check_a("drain_c", 1'b1, 2'd1, 1'b1, 8'h0C);
        a_in_valid = 1'b0;
        step();
        check_a("drain_empty", 1'b0, 2'd0, 1'b1, 8'h00);

        // Flush while full, with a coincident push and pop
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h0A;
        step();
        a_in_data = 8'h0B;
        step();
        check("pre_flush.occupancy", 32'(a_occ), 32'd2);
        a_flush     = 1'b1;
        a_in_data   = 8'h0C;
        a_out_ready = 1'b1;
        step();
        check_a("flush", 1'b0, 2'd0, 1'b1, 8'h00);
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_flush%0d.out_valid", i), 32'(a_out_valid), 32'd0);
        end

        // Asynchronous reset while full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h0A;
        step();
        a_in_data = 8'h0B;
        step();
        a_in_valid = 1'b0;
        check("pre_reset.occupancy", 32'(a_occ), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_a("async_reset", 1'b0, 2'd0, 1'b1, 8'h00);
        @(negedge stg_clk);
        reset = 1'b1;

        // Single-register variant: combinational in_ready
        b_in_valid  = 1'b1;
        b_in_data   = 8'h04;
        b_out_ready = 1'b0;
        step();
        check("b_hold.out_data", 32'(b_out_data), 32'h04);
        check("b_hold.occupancy", 32'(b_occ), 32'd1);
        b_in_valid = 1'b0;
        #1;
        check("b_stall.in_ready", 32'(b_in_ready), 32'd0);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h05;
        #1;
        check("b_release.in_ready", 32'(b_in_ready), 32'd1);
        step();
        check("b_next.out_data", 32'(b_out_data), 32'h05);
        check("b_next.occupancy", 32'(b_occ), 32'd1);
        b_in_valid = 1'b0;
        step();
        check("b_pop.out_valid", 32'(b_out_valid), 32'd0);
        check("b_pop.out_data", 32'(b_out_data), 32'h00);
        check("b_pop.occupancy", 32'(b_occ), 32'd0);

        // Single-register flush beats a coincident push
        b_in_valid  = 1'b1;
        b_in_data   = 8'h06;
        b_out_ready = 1'b0;
        step();
        b_flush   = 1'b1;
        b_in_data = 8'h07;
        step();
        check("b_flush.out_valid", 32'(b_out_valid), 32'd0);
        check("b_flush.out_data", 32'(b_out_data), 32'h00);
        b_flush    = 1'b0;
        b_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
